// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller: op encodings, FSM states and
// the supported latency range.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    OpRead  = 3'd0,
    OpWrite = 3'd1,
    OpInc   = 3'd2,
    OpDec   = 3'd3,
    OpClear = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRmwWr,
    StClear,
    StDone
  } state_e;

  localparam int unsigned LatMin  = 1;
  localparam int unsigned LatMax  = 4;
  // Wide enough to count up to LatMax.
  localparam int unsigned LatCntW = 3;

  // Encodings 5..7 are reserved and flagged as errors.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous memory: one-cycle registered read, write enable,
// no reset on the storage so contents survive controller resets.
module ram_array #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled; always return the addressed cell one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: accepts one op at a time, waits LAT cycles for the array,
// performs read / write / increment / decrement / full clear and reports
// completion with a one-cycle Ack (or Err for a reserved op code).
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LAT    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic [2:0]        Op,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              Ack,
  output logic              Err
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic [LatCntW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 err_q, err_d;

  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;
  logic [DATA_W-1:0]    rmw_val;
  logic                 accept;
  logic                 lat_hit;

  assign Ready   = (state_q == StIdle) || (state_q == StDone);
  assign Ack     = (state_q == StDone);
  assign Err     = err_q;
  assign DataOut = dout_q;
  assign accept  = Req && Ready;
  assign lat_hit = (lat_cnt_q == LatCntW'(LAT));
  assign rmw_val = (op_q == OpInc) ? ram_rdata + DATA_W'(1) : ram_rdata - DATA_W'(1);

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram_array (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, datapath and array-port control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    din_d      = din_q;
    lat_cnt_d  = lat_cnt_q;
    clr_addr_d = clr_addr_q;
    dout_d     = dout_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_wdata  = din_q;

    case (state_q)
      StIdle, StDone: begin
        // Drive the live address so the array read starts at the accept edge.
        ram_addr = Address;
        state_d  = StIdle;
        if (accept) begin
          addr_d     = Address;
          din_d      = DataIn;
          lat_cnt_d  = LatCntW'(1);
          clr_addr_d = '0;
          if (!op_legal(Op)) begin
            err_d = 1'b1;
          end else begin
            op_d    = op_e'(Op);
            state_d = (op_e'(Op) == OpClear) ? StClear : StWait;
          end
        end
      end
      StWait: begin
        if (lat_hit) begin
          lat_cnt_d = '0;
          if (op_q == OpWrite) begin
            ram_we  = 1'b1;
            dout_d  = din_q;
            state_d = StDone;
          end else if (op_q == OpRead) begin
            dout_d  = ram_rdata;
            state_d = StDone;
          end else begin
            state_d = StRmwWr;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LatCntW'(1);
        end
      end
      StRmwWr: begin
        ram_we    = 1'b1;
        ram_wdata = rmw_val;
        dout_d    = rmw_val;
        state_d   = StDone;
      end
      StClear: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          dout_d  = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and result registers; the array itself is not reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      op_q       <= OpRead;
      addr_q     <= '0;
      din_q      <= '0;
      lat_cnt_q  <= '0;
      clr_addr_q <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      lat_cnt_q  <= lat_cnt_d;
      clr_addr_q <= clr_addr_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: instance a (ADDR_W=8, LAT=1) and
// instance b (ADDR_W=4, LAT=3) share stimulus, selected by sel.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       sel;
  logic [2:0] op;
  logic [7:0] address;
  logic [7:0] data_in;

  logic       req_a, ready_a, ack_a, err_a;
  logic       req_b, ready_b, ack_b, err_b;
  logic [7:0] dout_a, dout_b;
  logic       ack_m;
  logic [7:0] dout_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign req_a  = req & ~sel;
  assign req_b  = req & sel;
  assign ack_m  = sel ? ack_b : ack_a;
  assign dout_m = sel ? dout_b : dout_a;

  ram_ctrl #(.ADDR_W(8), .DATA_W(8), .LAT(1)) u_dut_a (
    .Clk     (clk),
    .Rst     (rst),
    .Req     (req_a),
    .Op      (op),
    .Address (address),
    .DataIn  (data_in),
    .DataOut (dout_a),
    .Ready   (ready_a),
    .Ack     (ack_a),
    .Err     (err_a)
  );

  ram_ctrl #(.ADDR_W(4), .DATA_W(8), .LAT(3)) u_dut_b (
    .Clk     (clk),
    .Rst     (rst),
    .Req     (req_b),
    .Op      (op),
    .Address (address[3:0]),
    .DataIn  (data_in),
    .DataOut (dout_b),
    .Ready   (ready_b),
    .Ack     (ack_b),
    .Err     (err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op; cyc is the cycle index (1 = cycle after accept) of the Ack,
  // or -1 if no Ack arrived within the budget.
  task automatic do_op(input logic s, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] d, output int cyc, output logic [7:0] res);
    @(negedge clk);
    sel = s; req = 1'b1; op = o; address = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    while (!ack_m && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!ack_m) cyc = -1;
    res = dout_m;
  endtask

  task automatic fill_b(input logic [7:0] d);
    int         c;
    logic [7:0] r;
    for (int i = 0; i < 16; i++) do_op(1'b1, 3'd1, 8'(i), d, c, r);
  endtask

  initial begin
    int         cyc;
    int         acks;
    logic [7:0] res;

    rst = 1'b1; req = 1'b0; sel = 1'b0; op = 3'd0; address = '0; data_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready_a", ready_a, 1);
    check_eq("rst_ack_a", ack_a, 0);
    check_eq("rst_err_a", err_a, 0);
    check_eq("rst_dout_a", dout_a, 0);
    check_eq("rst_ready_b", ready_b, 1);
    rst = 1'b0;

    // LAT=1 write then read.
    do_op(1'b0, 3'd1, 8'h10, 8'h3C, cyc, res);
    check_eq("wr_lat1_cyc", cyc, 2);
    check_eq("wr_lat1_dout", res, 8'h3C);
    do_op(1'b0, 3'd0, 8'h10, 8'h00, cyc, res);
    check_eq("rd_lat1_cyc", cyc, 2);
    check_eq("rd_lat1_dout", res, 8'h3C);
    @(negedge clk);
    check_eq("ack_one_cycle", ack_a, 0);
    do_op(1'b0, 3'd1, 8'h11, 8'h5A, cyc, res);
    do_op(1'b0, 3'd0, 8'h10, 8'h00, cyc, res);
    check_eq("rd_0x10_again", res, 8'h3C);
    do_op(1'b0, 3'd0, 8'h11, 8'h00, cyc, res);
    check_eq("rd_0x11", res, 8'h5A);

    // LAT=3 INC/DEC with wrap.
    do_op(1'b1, 3'd1, 8'h3, 8'hFF, cyc, res);
    check_eq("wr_lat3_cyc", cyc, 4);
    do_op(1'b1, 3'd2, 8'h3, 8'h00, cyc, res);
    check_eq("inc_lat3_cyc", cyc, 5);
    check_eq("inc_wrap_dout", res, 8'h00);
    do_op(1'b1, 3'd0, 8'h3, 8'h00, cyc, res);
    check_eq("rd_lat3_cyc", cyc, 4);
    check_eq("inc_wrap_reread", res, 8'h00);
    do_op(1'b1, 3'd1, 8'h4, 8'h00, cyc, res);
    do_op(1'b1, 3'd3, 8'h4, 8'h00, cyc, res);
    check_eq("dec_wrap_dout", res, 8'hFF);
    do_op(1'b1, 3'd0, 8'h4, 8'h00, cyc, res);
    check_eq("dec_wrap_reread", res, 8'hFF);
    do_op(1'b1, 3'd1, 8'h7, 8'h41, cyc, res);
    do_op(1'b1, 3'd2, 8'h7, 8'h00, cyc, res);
    check_eq("inc_plain_dout", res, 8'h42);

    // Illegal op.
    @(negedge clk);
    sel = 1'b1; req = 1'b1; op = 3'd6; address = 8'h3; data_in = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check_eq("illegal_err", err_b, 1);
    check_eq("illegal_no_ack", ack_b, 0);
    check_eq("illegal_ready", ready_b, 1);
    @(negedge clk);
    check_eq("illegal_err_pulse", err_b, 0);
    check_eq("illegal_no_ack2", ack_b, 0);
    do_op(1'b1, 3'd0, 8'h3, 8'h00, cyc, res);
    check_eq("illegal_cell_kept", res, 8'h00);

    // Req while busy is ignored without Err.
    @(negedge clk);
    sel = 1'b1; req = 1'b1; op = 3'd0; address = 8'h7;
    @(posedge clk);
    @(negedge clk);
    op = 3'd6;
    check_eq("busy_not_ready", ready_b, 0);
    check_eq("busy_no_err", err_b, 0);
    cyc = 1;
    @(negedge clk);
    cyc++;
    check_eq("busy_no_err2", err_b, 0);
    req = 1'b0;
    while (!ack_b && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("busy_rd_cyc", cyc, 4);
    check_eq("busy_rd_dout", dout_b, 8'h42);

    // Full clear.
    fill_b(8'hA5);
    do_op(1'b1, 3'd4, 8'h9, 8'h00, cyc, res);
    check_eq("clr_cyc", cyc, 17);
    check_eq("clr_dout", res, 8'h00);
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 3'd0, 8'(i), 8'h00, cyc, res);
      check_eq($sformatf("clr_cell%0d", i), res, 8'h00);
    end

    // Reset just after edge E0+5 of a clear.
    fill_b(8'hA5);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; op = 3'd4; address = 8'h0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_ready", ready_b, 1);
    check_eq("abort_no_ack", ack_b, 0);
    check_eq("abort_dout", dout_b, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_b) acks++;
    end
    check_eq("abort_ack_count", acks, 0);
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 3'd0, 8'(i), 8'h00, cyc, res);
      check_eq($sformatf("abort_cell%0d", i), res, (i < 5) ? 8'h00 : 8'hA5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
